branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_pkg.sv | 25 ++
 rtl/br_cmp_core.sv | 45 ++++
 rtl/branch_resolve_unit.sv | 163 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch resolve unit: compare-code encodings
// (RISC-V funct3 for conditional branches), the RUN/FLUSH state type and the
// width of the wrong-path flush down-counter.
// -----------------------------------------------------------------------------
package branch_pkg;

    // Compare codes; 3'b010 and 3'b011 are unused and resolve not-taken.
    localparam logic [2:0] CMP_EQ  = 3'b000;
    localparam logic [2:0] CMP_NE  = 3'b001;
    localparam logic [2:0] CMP_LT  = 3'b100;
    localparam logic [2:0] CMP_GE  = 3'b101;
    localparam logic [2:0] CMP_LTU = 3'b110;
    localparam logic [2:0] CMP_GEU = 3'b111;

    // Flush counter holds FLUSH_CYCLES, whose legal range is 1..15.
    localparam int FLUSH_CNT_W = 4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } br_state_e;

endpackage : branch_pkg

// File: rtl/br_cmp_core.sv
// -----------------------------------------------------------------------------
// br_cmp_core
// Purely combinational branch comparator. Evaluates the branch condition
// selected by the compare code on two XLEN-bit operands.
//
// Ports:
//   i_op_a, i_op_b : compare operands
//   i_comp_ctl     : compare code (funct3)
//   o_taken        : 1 when the selected condition holds
// -----------------------------------------------------------------------------
module br_cmp_core
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic [2:0]      i_comp_ctl,
    output logic            o_taken
);

    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = (i_op_a == i_op_b);
    assign w_lt  = ($signed(i_op_a) < $signed(i_op_b));
    assign w_ltu = (i_op_a < i_op_b);

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves
        // o_taken unassigned, which would otherwise infer a latch.
        o_taken = 1'b0;
        case (i_comp_ctl)
            CMP_EQ:  o_taken = w_eq;
            CMP_NE:  o_taken = !w_eq;
            CMP_LT:  o_taken = w_lt;
            CMP_GE:  o_taken = !w_lt;
            CMP_LTU: o_taken = w_ltu;
            CMP_GEU: o_taken = !w_ltu;
            default: o_taken = 1'b0;
        endcase
    end

endmodule : br_cmp_core

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Resolves conditional branches one cycle after acceptance, flags mispredicts,
// issues a one-cycle fetch redirect and then discards wrong-path requests for
// FLUSH_CYCLES cycles. Keeps saturating branch / mispredict statistics.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid / in_ready      : request handshake
//   br_en                    : request is a conditional branch (0 = pass-through)
//   op_a, op_b, comp_ctl     : compare operands and compare code
//   pc, imm, pred_taken      : branch PC, sign-extended offset, prediction
//   out_valid / out_ready    : registered result handshake
//   taken, mispredict        : resolved direction, prediction error
//   redirect_valid/_pc       : one-cycle redirect pulse and correct next PC
//   flushing                 : unit is discarding wrong-path requests
//   br_count, mp_count       : saturating statistics counters
// -----------------------------------------------------------------------------
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             br_en,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic [2:0]       comp_ctl,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic             mispredict,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flushing,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0]       CNT_MAX    = '1;

    br_state_e              r_state;
    logic [FLUSH_CNT_W-1:0] r_flush_cnt;
    logic                   r_out_valid;
    logic                   r_taken;
    logic                   r_mispredict;
    logic                   r_redirect_valid;
    logic [XLEN-1:0]        r_redirect_pc;
    logic [CNT_W-1:0]       r_br_count;
    logic [CNT_W-1:0]       r_mp_count;

    logic                   w_cmp_taken;
    logic                   w_taken;
    logic                   w_mispredict;
    logic                   w_run_accept;
    logic [XLEN-1:0]        w_next_pc;

    br_cmp_core #(
        .XLEN (XLEN)
    ) u_cmp (
        .i_op_a     (op_a),
        .i_op_b     (op_b),
        .i_comp_ctl (comp_ctl),
        .o_taken    (w_cmp_taken)
    );

    // FLUSH always accepts so the front end can drain wrong-path requests.
    assign in_ready     = (r_state == ST_FLUSH) || !r_out_valid || out_ready;

    // Only requests accepted in RUN produce results or touch the counters.
    assign w_run_accept = in_valid && in_ready && (r_state == ST_RUN);

    assign w_taken      = br_en && w_cmp_taken;
    assign w_mispredict = br_en && (w_taken != pred_taken);
    // Both sums wrap modulo 2^XLEN.
    assign w_next_pc    = w_taken ? (pc + imm) : (pc + XLEN'(4));

    // Control FSM and result register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout sequential logic so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state          <= ST_RUN;
            r_flush_cnt      <= '0;
            r_out_valid      <= 1'b0;
            r_taken          <= 1'b0;
            r_mispredict     <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            // Redirect is a single pulse on the load cycle; a stalled result
            // keeps its fields but never re-raises the pulse.
            r_redirect_valid <= 1'b0;

            if (w_run_accept) begin
                r_out_valid      <= 1'b1;
                r_taken          <= w_taken;
                r_mispredict     <= w_mispredict;
                r_redirect_pc    <= w_next_pc;
                r_redirect_valid <= w_mispredict;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_RUN: begin
                    // Enter FLUSH on the same edge the redirect is raised so
                    // the very next request is already treated as wrong-path.
                    if (w_run_accept && w_mispredict) begin
                        r_state     <= ST_FLUSH;
                        r_flush_cnt <= FLUSH_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if (r_flush_cnt <= FLUSH_CNT_W'(1)) begin
                        r_state     <= ST_RUN;
                        r_flush_cnt <= '0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - FLUSH_CNT_W'(1);
                    end
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_flush_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_count <= '0;
            r_mp_count <= '0;
        end else begin
            if (w_run_accept && br_en && (r_br_count != CNT_MAX)) begin
                r_br_count <= r_br_count + CNT_W'(1);
            end
            if (w_run_accept && w_mispredict && (r_mp_count != CNT_MAX)) begin
                r_mp_count <= r_mp_count + CNT_W'(1);
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign taken          = r_taken;
    assign mispredict     = r_mispredict;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flushing       = (r_state == ST_FLUSH);
    assign br_count       = r_br_count;
    assign mp_count       = r_mp_count;

endmodule : branch_resolve_unit

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed bench for branch_resolve_unit. A default instance (CNT_W=16) and a
// second instance with CNT_W=2 share all inputs; the second one exposes
// counter saturation. Inputs are driven 1 time unit after the rising edge and
// outputs are sampled at the same point, one full cycle after being driven.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        br_en;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0]  comp_ctl;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred_taken;
    logic        out_ready;

    logic        in_ready, out_valid, taken, mispredict, redirect_valid, flushing;
    logic [31:0] redirect_pc;
    logic [15:0] br_count, mp_count;

    logic        s_in_ready, s_out_valid, s_taken, s_mispredict, s_redirect_valid, s_flushing;
    logic [31:0] s_redirect_pc;
    logic [1:0]  s_br_count, s_mp_count;

    int vectors     = 0;
    int miscompares = 0;
    int exp_br      = 0;
    int exp_mp      = 0;

    branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .br_en(br_en), .op_a(op_a), .op_b(op_b), .comp_ctl(comp_ctl),
        .pc(pc), .imm(imm), .pred_taken(pred_taken),
        .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
        .mispredict(mispredict), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flushing(flushing),
        .br_count(br_count), .mp_count(mp_count)
    );

    branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .br_en(br_en), .op_a(op_a), .op_b(op_b), .comp_ctl(comp_ctl),
        .pc(pc), .imm(imm), .pred_taken(pred_taken),
        .out_valid(s_out_valid), .out_ready(out_ready), .taken(s_taken),
        .mispredict(s_mispredict), .redirect_valid(s_redirect_valid),
        .redirect_pc(s_redirect_pc), .flushing(s_flushing),
        .br_count(s_br_count), .mp_count(s_mp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic br, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] ctl,
                         input logic [31:0] p, input logic [31:0] i,
                         input logic pr);
        in_valid   = v;
        br_en      = br;
        op_a       = a;
        op_b       = b;
        comp_ctl   = ctl;
        pc         = p;
        imm        = i;
        pred_taken = pr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        vectors++;
        if ({out_valid, taken, mispredict, redirect_valid} !== 4'b0000) begin
            $display("FAIL reset_flags: got %b expected 0000", {out_valid, taken, mispredict, redirect_valid});
            miscompares++;
        end
        vectors++;
        if (redirect_pc !== 32'h0) begin
            $display("FAIL reset_pc: got %h expected 00000000", redirect_pc);
            miscompares++;
        end
        vectors++;
        if ({br_count, mp_count, s_br_count, s_mp_count} !== 36'h0) begin
            $display("FAIL reset_counts: got br=%0d mp=%0d sbr=%0d smp=%0d expected all 0",
                     br_count, mp_count, s_br_count, s_mp_count);
            miscompares++;
        end
        vectors++;
        if (flushing !== 1'b0) begin
            $display("FAIL reset_flushing: got %b expected 0", flushing);
            miscompares++;
        end
        rst = 1'b0;
        tick();
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin
            $display("FAIL post_reset_ready: got in_ready/out_valid %b expected 10", {in_ready, out_valid});
            miscompares++;
        end
    endtask

    task automatic test_compare();
        logic [2:0]  ctl_t [12] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100, 3'b101,
                                    3'b110, 3'b111, 3'b010, 3'b011, 3'b100, 3'b110};
        logic [31:0] a_t   [12] = '{32'd5, 32'd5, 32'd5, 32'd9, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                    32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd5, 32'd1, 32'd1};
        logic [31:0] b_t   [12] = '{32'd5, 32'd6, 32'd6, 32'd9, 32'd1, 32'd1,
                                    32'd1, 32'd1, 32'd5, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic        t_t   [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] exp_pc;
        out_ready = 1'b1;
        // Back-to-back stream, correctly predicted: one result per cycle.
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 1'b1, a_t[k], b_t[k], ctl_t[k], 32'h1000, 32'h40, t_t[k]);
            tick();
            exp_br++;
            exp_pc = t_t[k] ? 32'h1040 : 32'h1004;
            vectors++;
            if ({out_valid, taken, mispredict, redirect_valid} !== {1'b1, t_t[k], 2'b00}) begin
                $display("FAIL compare[%0d] flags: got %b expected %b", k,
                         {out_valid, taken, mispredict, redirect_valid}, {1'b1, t_t[k], 2'b00});
                miscompares++;
            end
            vectors++;
            if (redirect_pc !== exp_pc) begin
                $display("FAIL compare[%0d] pc: got %h expected %h", k, redirect_pc, exp_pc);
                miscompares++;
            end
            vectors++;
            if ({in_ready, flushing} !== 2'b10 || br_count !== 16'(exp_br)) begin
                $display("FAIL compare[%0d] ready/flush/count: got %b br=%0d expected 10 br=%0d",
                         k, {in_ready, flushing}, br_count, exp_br);
                miscompares++;
            end
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0);
        tick();
        vectors++;
        if (out_valid !== 1'b0 || mp_count !== 16'(exp_mp)) begin
            $display("FAIL compare_drain: got out_valid=%b mp=%0d expected 0 mp=%0d", out_valid, mp_count, exp_mp);
            miscompares++;
        end
    endtask

    task automatic test_passthrough();
        // Would be taken and mispredicted if it were a branch.
        drive(1'b1, 1'b0, 32'd7, 32'd7, 3'b000, 32'h500, 32'h80, 1'b1);
        tick();
        vectors++;
        if ({out_valid, taken, mispredict, redirect_valid, flushing} !== 5'b10000) begin
            $display("FAIL passthrough flags: got %b expected 10000",
                     {out_valid, taken, mispredict, redirect_valid, flushing});
            miscompares++;
        end
        vectors++;
        if (redirect_pc !== 32'h504) begin
            $display("FAIL passthrough pc: got %h expected 00000504", redirect_pc);
            miscompares++;
        end
        vectors++;
        if (br_count !== 16'(exp_br) || mp_count !== 16'(exp_mp)) begin
            $display("FAIL passthrough counts: got br=%0d mp=%0d expected br=%0d mp=%0d",
                     br_count, mp_count, exp_br, exp_mp);
            miscompares++;
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0);
        tick();
    endtask

    task automatic test_mispredict_flush();
        out_ready = 1'b1;
        // -1 <s 1 is taken, predicted not-taken.
        drive(1'b1, 1'b1, 32'hFFFFFFFF, 32'd1, 3'b100, 32'h2000, 32'hFFFFFF00, 1'b0);
        tick();
        exp_br++;
        exp_mp++;
        vectors++;
        if ({out_valid, taken, mispredict, redirect_valid} !== 4'b1111) begin
            $display("FAIL mispredict flags: got %b expected 1111", {out_valid, taken, mispredict, redirect_valid});
            miscompares++;
        end
        vectors++;
        if (redirect_pc !== 32'h00001F00) begin
            $display("FAIL mispredict pc: got %h expected 00001f00", redirect_pc);
            miscompares++;
        end
        vectors++;
        if ({flushing, in_ready} !== 2'b11 || mp_count !== 16'(exp_mp)) begin
            $display("FAIL mispredict flush_entry: got flush/ready=%b mp=%0d expected 11 mp=%0d",
                     {flushing, in_ready}, mp_count, exp_mp);
            miscompares++;
        end
        // Wrong-path requests for the two flush cycles.
        drive(1'b1, 1'b1, 32'd1, 32'd1, 3'b000, 32'h9000, 32'h4, 1'b0);
        tick();
        vectors++;
        if ({out_valid, redirect_valid, flushing} !== 3'b001) begin
            $display("FAIL flush_cycle2: got valid/redir/flush=%b expected 001", {out_valid, redirect_valid, flushing});
            miscompares++;
        end
        tick();
        vectors++;
        if ({out_valid, flushing} !== 2'b00) begin
            $display("FAIL flush_exit: got valid/flush=%b expected 00", {out_valid, flushing});
            miscompares++;
        end
        vectors++;
        if (br_count !== 16'(exp_br) || mp_count !== 16'(exp_mp)) begin
            $display("FAIL flush_counts: got br=%0d mp=%0d expected br=%0d mp=%0d", br_count, mp_count, exp_br, exp_mp);
            miscompares++;
        end
        // RUN resumes: correctly predicted taken branch.
        drive(1'b1, 1'b1, 32'd2, 32'd2, 3'b000, 32'h4000, 32'h20, 1'b1);
        tick();
        exp_br++;
        vectors++;
        if ({out_valid, taken, mispredict, redirect_valid, flushing} !== 5'b11000 || redirect_pc !== 32'h4020) begin
            $display("FAIL resume: got flags=%b pc=%h expected 11000 pc=00004020",
                     {out_valid, taken, mispredict, redirect_valid, flushing}, redirect_pc);
            miscompares++;
        end
        vectors++;
        if (br_count !== 16'(exp_br)) begin
            $display("FAIL resume_count: got br=%0d expected %0d", br_count, exp_br);
            miscompares++;
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0);
        tick();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 32'd7, 32'd7, 3'b000, 32'h3000, 32'h10, 1'b0);
        tick();
        exp_br++;
        exp_mp++;
        vectors++;
        if ({out_valid, taken, mispredict, redirect_valid} !== 4'b1111 || redirect_pc !== 32'h3010) begin
            $display("FAIL stall_c1: got flags=%b pc=%h expected 1111 pc=00003010",
                     {out_valid, taken, mispredict, redirect_valid}, redirect_pc);
            miscompares++;
        end
        // Different request held on the inputs throughout the stall.
        drive(1'b1, 1'b1, 32'd1, 32'd2, 3'b000, 32'h7000, 32'h4, 1'b0);
        tick();
        vectors++;
        if ({out_valid, taken, mispredict, redirect_valid} !== 4'b1110 || redirect_pc !== 32'h3010) begin
            $display("FAIL stall_c2: got flags=%b pc=%h expected 1110 pc=00003010",
                     {out_valid, taken, mispredict, redirect_valid}, redirect_pc);
            miscompares++;
        end
        vectors++;
        if ({in_ready, flushing} !== 2'b11) begin
            $display("FAIL stall_c2_ready: got ready/flush=%b expected 11", {in_ready, flushing});
            miscompares++;
        end
        tick();
        vectors++;
        if ({out_valid, taken, mispredict, redirect_valid} !== 4'b1110 || redirect_pc !== 32'h3010) begin
            $display("FAIL stall_c3: got flags=%b pc=%h expected 1110 pc=00003010",
                     {out_valid, taken, mispredict, redirect_valid}, redirect_pc);
            miscompares++;
        end
        vectors++;
        if ({in_ready, flushing} !== 2'b00) begin
            $display("FAIL stall_c3_ready: got ready/flush=%b expected 00", {in_ready, flushing});
            miscompares++;
        end
        tick();
        vectors++;
        if ({out_valid, redirect_valid, in_ready} !== 3'b100 || br_count !== 16'(exp_br) || mp_count !== 16'(exp_mp)) begin
            $display("FAIL stall_c4: got valid/redir/ready=%b br=%0d mp=%0d expected 100 br=%0d mp=%0d",
                     {out_valid, redirect_valid, in_ready}, br_count, mp_count, exp_br, exp_mp);
            miscompares++;
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0);
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("FAIL stall_drain: got out_valid=%b expected 0", out_valid);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_flush();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 32'd7, 32'd7, 3'b000, 32'h3000, 32'h10, 1'b0);
        tick();
        exp_br++;
        exp_mp++;
        vectors++;
        if (flushing !== 1'b1 || mp_count !== 16'(exp_mp)) begin
            $display("FAIL rstflush_c1: got flush=%b mp=%0d expected 1 mp=%0d", flushing, mp_count, exp_mp);
            miscompares++;
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0);
        tick();
        vectors++;
        if ({flushing, out_valid} !== 2'b11) begin
            $display("FAIL rstflush_c2: got flush/valid=%b expected 11", {flushing, out_valid});
            miscompares++;
        end
        rst = 1'b1;
        tick();
        exp_br = 0;
        exp_mp = 0;
        vectors++;
        if ({flushing, out_valid, taken, mispredict, redirect_valid} !== 5'b00000 || redirect_pc !== 32'h0) begin
            $display("FAIL rstflush_state: got flags=%b pc=%h expected 00000 pc=00000000",
                     {flushing, out_valid, taken, mispredict, redirect_valid}, redirect_pc);
            miscompares++;
        end
        vectors++;
        if ({br_count, mp_count, s_br_count, s_mp_count} !== 36'h0) begin
            $display("FAIL rstflush_counts: got br=%0d mp=%0d sbr=%0d smp=%0d expected all 0",
                     br_count, mp_count, s_br_count, s_mp_count);
            miscompares++;
        end
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        vectors++;
        if ({flushing, out_valid, in_ready} !== 3'b001) begin
            $display("FAIL rstflush_after: got flush/valid/ready=%b expected 001", {flushing, out_valid, in_ready});
            miscompares++;
        end
    endtask

    task automatic test_wrap_sat();
        logic [31:0] pc_t  [5] = '{32'hFFFFFFFC, 32'hFFFFFFF0, 32'h100, 32'h200, 32'h300};
        logic [31:0] imm_t [5] = '{32'h100, 32'h20, 32'h8, 32'h8, 32'h8};
        logic [31:0] a_t   [5] = '{32'd1, 32'd3, 32'd3, 32'd3, 32'd3};
        logic [31:0] b_t   [5] = '{32'd2, 32'd3, 32'd3, 32'd3, 32'd3};
        logic        t_t   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] pcx_t [5] = '{32'h00000000, 32'h00000010, 32'h108, 32'h208, 32'h308};
        logic [1:0]  sat_t [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, a_t[k], b_t[k], 3'b000, pc_t[k], imm_t[k], t_t[k]);
            tick();
            exp_br++;
            vectors++;
            if ({out_valid, taken, mispredict} !== {1'b1, t_t[k], 1'b0} || redirect_pc !== pcx_t[k]) begin
                $display("FAIL wrap[%0d]: got flags=%b pc=%h expected %b pc=%h", k,
                         {out_valid, taken, mispredict}, redirect_pc, {1'b1, t_t[k], 1'b0}, pcx_t[k]);
                miscompares++;
            end
            vectors++;
            if (br_count !== 16'(exp_br) || s_br_count !== sat_t[k]) begin
                $display("FAIL sat[%0d]: got br=%0d sat_br=%0d expected br=%0d sat_br=%0d", k,
                         br_count, s_br_count, exp_br, sat_t[k]);
                miscompares++;
            end
            vectors++;
            if ({s_out_valid, s_taken, s_mispredict, s_redirect_valid} !== {1'b1, t_t[k], 2'b00} ||
                s_redirect_pc !== pcx_t[k]) begin
                $display("FAIL sat_result[%0d]: got flags=%b pc=%h expected %b pc=%h", k,
                         {s_out_valid, s_taken, s_mispredict, s_redirect_valid}, s_redirect_pc,
                         {1'b1, t_t[k], 2'b00}, pcx_t[k]);
                miscompares++;
            end
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0);
        tick();
        vectors++;
        if (s_br_count !== 2'd3 || s_mp_count !== 2'd0 || br_count !== 16'd5 || {s_in_ready, s_flushing} !== 2'b10) begin
            $display("FAIL sat_final: got sbr=%0d smp=%0d br=%0d ready/flush=%b expected 3 0 5 10",
                     s_br_count, s_mp_count, br_count, {s_in_ready, s_flushing});
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_compare();
        test_passthrough();
        test_mispredict_flush();
        test_stall();
        test_reset_mid_flush();
        test_wrap_sat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_branch_resolve_unit
